// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback
// requesters, with a registered write stage and a 32-entry pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic               rf_we,
  output logic [AW-1:0]      rf_wa,
  output logic [DW-1:0]      rf_wd,
  output logic [2:0]         grant_id,
  input  logic               claim_valid,
  input  logic [AW-1:0]      claim_addr,
  output logic [31:0]        pending
);

  localparam logic [2:0] LAST = 3'(NREQ - 1);

  logic [2:0]    ptr;
  logic [2:0]    gnt_idx;
  logic          accept;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic [31:0]   set_mask;
  logic [31:0]   clr_mask;
  logic [31:0]   pending_d;

  // Two-pass search: indices at or above ptr first, then wrap to the low indices.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    accept    = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!accept && req_valid[i] && (3'(i) >= ptr)) begin
        accept       = 1'b1;
        gnt_idx      = 3'(i);
        req_ready[i] = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!accept && req_valid[i]) begin
        accept       = 1'b1;
        gnt_idx      = 3'(i);
        req_ready[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && (3'(i) == gnt_idx)) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Set is applied after clear so a same-cycle reclaim by a newer instruction wins.
  always_comb begin
    set_mask  = claim_valid ? (32'd1 << claim_addr) : 32'd0;
    clr_mask  = accept ? (32'd1 << sel_addr) : 32'd0;
    pending_d = ((pending & ~clr_mask) | set_mask) & ~32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_wa    <= '0;
      rf_wd    <= '0;
      grant_id <= '0;
      ptr      <= '0;
      pending  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      rf_we   <= accept && (sel_addr != '0);
      pending <= pending_d;
      if (accept) begin
        rf_wa    <= sel_addr;
        rf_wd    <= sel_data;
        grant_id <= gnt_idx;
        ptr      <= (gnt_idx == LAST) ? 3'd0 : gnt_idx + 3'd1;
      end
    end
  end

endmodule
